max7219_spi_receiver: RTL and testbench
=======================================

// Module: max7219_spi_receiver
// PURPOSE
//   SPI responder for the 16-bit display-driver link produced by SPI_driver. Oversamples cs/sclk/mosi
//   on the 1 MHz system clock, assembles MSB-first words, commits on cs rising edge into a
//   MAX7219-compatible register file (digits, decode, intensity, scan limit, shutdown, test).
//   Serves as the on-chip loopback checker and the display model for the stopwatch bench.
// PARAMETERS
//   SYNC_STAGES  2  synchroniser flops on cs, sclk, mosi (min 2)
//   NUM_DIGITS   8  implemented digit registers (1..8); digit addresses above this are ignored
// PORTS
//   clk           in   1  system clock (1 MHz nominal)
//   res           in   1  reset, asynchronous, active low
//   cs            in   1  SPI chip select, active low
//   sclk          in   1  SPI clock, mode 0 (sample on rising edge), max rate clk/4
//   mosi          in   1  SPI data, MSB first
//   rd_addr       in   3  digit read index (0 = digit 1 register, address 0x1)
//   rd_data       out  8  combinational read of digit register rd_addr (0 if >= NUM_DIGITS)
//   decode_mode   out  8  register 0x9
//   intensity     out  4  register 0xA, data[3:0]
//   scan_limit    out  3  register 0xB, data[2:0]
//   shutdown_n    out  1  register 0xC, data[0]; 0 = shutdown
//   display_test  out  1  register 0xF, data[0]
//   word_strobe   out  1  1-cycle pulse per committed word
//   word_addr     out  4  address of last committed word (held)
//   word_data     out  8  data of last committed word (held)
//   short_frame   out  1  1-cycle pulse: cs rose with fewer than 16 bits shifted
// BEHAVIOUR
//   Reset (async, res=0): all registers, digits, word_addr/data, shift reg, bit count = 0;
//     shutdown_n=0 (power-up shutdown); strobes 0; sync chains preset to cs=1, sclk=0, mosi=0.
//   Input path: each pin through SYNC_STAGES flops, plus one history flop on cs_s and sclk_s
//     for edge detect. Pin-to-edge-detect latency = SYNC_STAGES+1 clk.
//   Shift: on sclk_s rising (sclk_s=1, prev=0) while cs_s=0: sr <= {sr[14:0], mosi_s};
//     bit_cnt increments, saturating at 16. Words >16 bits keep the last 16 (MAX7219 rule).
//   Frame start: cs_s falling clears bit_cnt (sr not cleared).
//   Commit: cs_s rising edge; same cycle evaluate bit_cnt:
//     bit_cnt==16 -> decode sr, update register next edge, word_strobe=1 for one clk,
//       word_addr=sr[11:8], word_data=sr[7:0]. Outputs reflect the write 1 clk after edge detect.
//     bit_cnt<16  -> no register change, short_frame=1 for one clk, word_addr/data unchanged.
//   Decode on sr[11:8] (sr[15:12] don't-care):
//     0x0 no-op (strobe still pulses); 0x1..0x8 digit (addr-1) <= sr[7:0] if addr<=NUM_DIGITS;
//     0x9 decode_mode; 0xA intensity; 0xB scan_limit; 0xC shutdown_n; 0xF display_test;
//     0xD, 0xE ignored (strobe still pulses).
//   Simultaneous: sclk rise detected in same cycle as cs_s rise -> not shifted (cs_s already 1).
//     sclk edges while cs_s=1 are ignored entirely.
//   Reset mid-frame: partial word discarded; first frame after release needs a fresh cs fall.
//   Back-to-back frames: cs high for >= SYNC_STAGES+1 clk guarantees both edges are seen;
//     shorter glitches may be filtered, which is acceptable.
// TESTING
//   1 After reset, no SPI activity -> shutdown_n=0, intensity=0, all rd_data=0, no strobes.
//   2 Send 0x0C01, 0x0A05, 0x0B05, 0x093F (setup sequence) -> shutdown_n=1, intensity=5,
//     scan_limit=5, decode_mode=0x3F, four word_strobe pulses, word_addr=0x9 at end.
//   3 Send 0x0387 at clk/4 sclk -> rd_addr=2 gives 0x87, word_data=0x87; other digits unchanged.
//   4 Frame of 12 bits (0x0A0F truncated) -> short_frame pulse, intensity unchanged, no strobe.
//   5 20-bit frame 0xF_0105 -> last 16 bits 0x0105 commit: digit 1 = 0x05.
//   6 Assert res low after 8 bits of 0x0C01, release, then send 0x0201 -> shutdown_n stays 0,
//     digit 2 = 0x01, exactly one strobe after release.

Source files
------------

// File: rtl/max7219_spi_receiver_if.sv
// +--------------------------------------------------------------------+
// | max7219_spi_receiver_if : 3-wire SPI link to the display receiver   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface max7219_spi_receiver_if;
  logic cs;
  logic sclk;
  logic mosi;

  modport master (output cs, output sclk, output mosi);
  modport slave  (input  cs, input  sclk, input  mosi);
endinterface

`default_nettype wire

// File: rtl/max7219_spi_receiver.sv
// +--------------------------------------------------------------------+
// | max7219_spi_receiver : oversampled SPI slave + MAX7219 register file |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module max7219_spi_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_DIGITS  = 8
) (
  input  wire logic                   clk,
  input  wire logic                   res,
  max7219_spi_receiver_if.slave       spi,
  input  wire logic [2:0]             rd_addr,
  output logic      [7:0]             rd_data,
  output logic      [7:0]             decode_mode,
  output logic      [3:0]             intensity,
  output logic      [2:0]             scan_limit,
  output logic                        shutdown_n,
  output logic                        display_test,
  output logic                        word_strobe,
  output logic      [3:0]             word_addr,
  output logic      [7:0]             word_data,
  output logic                        short_frame
);

  localparam logic [3:0] c_num_digits = 4'(NUM_DIGITS);
  localparam logic [4:0] c_full_word  = 5'd16;

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_cs_d;
  logic                   r_sclk_d;
  // Only the low 12 bits of the 16-bit word are ever decoded, so the
  // upper nibble is shifted out immediately instead of being stored.
  logic [11:0]            r_sr;
  logic [4:0]             r_bit_cnt;
  logic [7:0]             r_digit [8];
  logic [7:0]             r_decode_mode;
  logic [3:0]             r_intensity;
  logic [2:0]             r_scan_limit;
  logic                   r_shutdown_n;
  logic                   r_display_test;
  logic                   r_word_strobe;
  logic                   r_short_frame;
  logic [3:0]             r_word_addr;
  logic [7:0]             r_word_data;

  logic       w_cs_s;
  logic       w_sclk_s;
  logic       w_mosi_s;
  logic       w_cs_fall;
  logic       w_cs_rise;
  logic       w_sclk_rise;
  logic       w_shift;
  logic       w_commit;
  logic       w_short;
  logic [2:0] w_digit_idx;

  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_fall   = r_cs_d & ~w_cs_s;
  assign w_cs_rise   = ~r_cs_d & w_cs_s;
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_shift     = w_sclk_rise & ~w_cs_s;
  assign w_commit    = w_cs_rise & (r_bit_cnt == c_full_word);
  assign w_short     = w_cs_rise & (r_bit_cnt != c_full_word);
  // Addresses 1..8 map to 0..7; address 8 wraps through 3'b000 - 1 = 7.
  assign w_digit_idx = r_sr[10:8] - 3'd1;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_cs_sync   <= {SYNC_STAGES{1'b1}};
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_d      <= 1'b1;
      r_sclk_d    <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi.cs};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      r_cs_d      <= w_cs_s;
      r_sclk_d    <= w_sclk_s;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (w_shift) begin
        r_sr <= {r_sr[10:0], w_mosi_s};
      end
      if (w_cs_fall) begin
        r_bit_cnt <= '0;
      end else if (w_shift && (r_bit_cnt != c_full_word)) begin
        r_bit_cnt <= r_bit_cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < 8; i++) begin
        r_digit[i] <= '0;
      end
      r_decode_mode  <= '0;
      r_intensity    <= '0;
      r_scan_limit   <= '0;
      r_shutdown_n   <= 1'b0;
      r_display_test <= 1'b0;
      r_word_strobe  <= 1'b0;
      r_short_frame  <= 1'b0;
      r_word_addr    <= '0;
      r_word_data    <= '0;
    end else begin
      r_word_strobe <= w_commit;
      r_short_frame <= w_short;
      if (w_commit) begin
        r_word_addr <= r_sr[11:8];
        r_word_data <= r_sr[7:0];
        case (r_sr[11:8])
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
            if (r_sr[11:8] <= c_num_digits) begin
              r_digit[w_digit_idx] <= r_sr[7:0];
            end
          end
          4'h9:    r_decode_mode  <= r_sr[7:0];
          4'hA:    r_intensity    <= r_sr[3:0];
          4'hB:    r_scan_limit   <= r_sr[2:0];
          4'hC:    r_shutdown_n   <= r_sr[0];
          4'hF:    r_display_test <= r_sr[0];
          default: ;
        endcase
      end
    end
  end

  assign rd_data      = ({1'b0, rd_addr} < c_num_digits) ? r_digit[rd_addr] : 8'h00;
  assign decode_mode  = r_decode_mode;
  assign intensity    = r_intensity;
  assign scan_limit   = r_scan_limit;
  assign shutdown_n   = r_shutdown_n;
  assign display_test = r_display_test;
  assign word_strobe  = r_word_strobe;
  assign word_addr    = r_word_addr;
  assign word_data    = r_word_data;
  assign short_frame  = r_short_frame;

endmodule

`default_nettype wire

// File: tb/tb_max7219_spi_receiver.sv
// +--------------------------------------------------------------------+
// | tb_max7219_spi_receiver : directed bench for the SPI display model  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_max7219_spi_receiver;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic [2:0] rd_addr = 3'd0;
  logic [7:0] rd_data;
  logic [7:0] decode_mode;
  logic [3:0] intensity;
  logic [2:0] scan_limit;
  logic       shutdown_n;
  logic       display_test;
  logic       word_strobe;
  logic [3:0] word_addr;
  logic [7:0] word_data;
  logic       short_frame;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  int short_cnt  = 0;
  int pulse_err  = 0;
  logic prev_strobe = 1'b0;

  max7219_spi_receiver_if spi ();

  max7219_spi_receiver #(.SYNC_STAGES(2), .NUM_DIGITS(8)) dut (
    .clk          (clk),
    .res          (res),
    .spi          (spi.slave),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .decode_mode  (decode_mode),
    .intensity    (intensity),
    .scan_limit   (scan_limit),
    .shutdown_n   (shutdown_n),
    .display_test (display_test),
    .word_strobe  (word_strobe),
    .word_addr    (word_addr),
    .word_data    (word_data),
    .short_frame  (short_frame)
  );

  always #500 clk = ~clk;

  always @(posedge clk) begin
    if (word_strobe) strobe_cnt <= strobe_cnt + 1;
    if (short_frame) short_cnt <= short_cnt + 1;
    if (word_strobe && prev_strobe) pulse_err <= pulse_err + 1;
    prev_strobe <= word_strobe;
  end

  // sclk at clk/4: two clocks low with data set up, two clocks high
  task automatic spi_frame(input logic [31:0] w, input int n);
    @(negedge clk);
    spi.cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      spi.mosi = w[i];
      repeat (2) @(negedge clk);
      spi.sclk = 1'b1;
      repeat (2) @(negedge clk);
      spi.sclk = 1'b0;
    end
    repeat (2) @(negedge clk);
    spi.cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    spi.cs = 1'b1; spi.sclk = 1'b0; spi.mosi = 1'b0;
    res = 1'b0;
    repeat (4) @(negedge clk);
    res = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (shutdown_n !== 1'b0) begin n_fail++; $display("FAIL reset_shutdown_n got %b expected 0", shutdown_n); end
    n_checks++;
    if (intensity !== 4'h0) begin n_fail++; $display("FAIL reset_intensity got %h expected 0", intensity); end
    n_checks++;
    if (decode_mode !== 8'h00 || scan_limit !== 3'h0 || display_test !== 1'b0) begin
      n_fail++; $display("FAIL reset_regs got dm=%h sl=%h dt=%b expected 0/0/0", decode_mode, scan_limit, display_test);
    end
    n_checks++;
    if (word_addr !== 4'h0 || word_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_word got %h/%h expected 0/00", word_addr, word_data);
    end
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      n_checks++;
      if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_digit%0d got %h expected 00", i, rd_data); end
    end
    n_checks++;
    if (strobe_cnt !== 0 || short_cnt !== 0) begin
      n_fail++; $display("FAIL reset_strobes got strobe=%0d short=%0d expected 0/0", strobe_cnt, short_cnt);
    end
  endtask

  task automatic test_setup;
    int s0;
    s0 = strobe_cnt;
    spi_frame(32'h0C01, 16);
    spi_frame(32'h0A05, 16);
    spi_frame(32'h0B05, 16);
    spi_frame(32'h093F, 16);
    n_checks++;
    if (shutdown_n !== 1'b1) begin n_fail++; $display("FAIL setup_shutdown_n got %b expected 1", shutdown_n); end
    n_checks++;
    if (intensity !== 4'h5) begin n_fail++; $display("FAIL setup_intensity got %h expected 5", intensity); end
    n_checks++;
    if (scan_limit !== 3'h5) begin n_fail++; $display("FAIL setup_scan_limit got %h expected 5", scan_limit); end
    n_checks++;
    if (decode_mode !== 8'h3F) begin n_fail++; $display("FAIL setup_decode_mode got %h expected 3f", decode_mode); end
    n_checks++;
    if (strobe_cnt - s0 !== 4) begin n_fail++; $display("FAIL setup_strobes got %0d expected 4", strobe_cnt - s0); end
    n_checks++;
    if (word_addr !== 4'h9 || word_data !== 8'h3F) begin
      n_fail++; $display("FAIL setup_word got %h/%h expected 9/3f", word_addr, word_data);
    end
  endtask

  task automatic test_digit_write;
    spi_frame(32'h0387, 16);
    rd_addr = 3'd2; #1;
    n_checks++;
    if (rd_data !== 8'h87) begin n_fail++; $display("FAIL digit3 got %h expected 87", rd_data); end
    n_checks++;
    if (word_addr !== 4'h3 || word_data !== 8'h87) begin
      n_fail++; $display("FAIL digit_word got %h/%h expected 3/87", word_addr, word_data);
    end
    rd_addr = 3'd1; #1;
    n_checks++;
    if (rd_data !== 8'h00) begin n_fail++; $display("FAIL digit2_untouched got %h expected 00", rd_data); end
    rd_addr = 3'd3; #1;
    n_checks++;
    if (rd_data !== 8'h00) begin n_fail++; $display("FAIL digit4_untouched got %h expected 00", rd_data); end
  endtask

  task automatic test_short_frame;
    int s0, h0;
    s0 = strobe_cnt; h0 = short_cnt;
    spi_frame(32'h0A0, 12);
    n_checks++;
    if (short_cnt - h0 !== 1) begin n_fail++; $display("FAIL short_pulse got %0d expected 1", short_cnt - h0); end
    n_checks++;
    if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL short_no_strobe got %0d expected 0", strobe_cnt - s0); end
    n_checks++;
    if (intensity !== 4'h5) begin n_fail++; $display("FAIL short_intensity got %h expected 5", intensity); end
    n_checks++;
    if (word_addr !== 4'h3 || word_data !== 8'h87) begin
      n_fail++; $display("FAIL short_word_held got %h/%h expected 3/87", word_addr, word_data);
    end
  endtask

  task automatic test_long_frame;
    int s0;
    s0 = strobe_cnt;
    spi_frame(32'hF0105, 20);
    rd_addr = 3'd0; #1;
    n_checks++;
    if (rd_data !== 8'h05) begin n_fail++; $display("FAIL long_digit1 got %h expected 05", rd_data); end
    n_checks++;
    if (strobe_cnt - s0 !== 1 || word_addr !== 4'h1) begin
      n_fail++; $display("FAIL long_strobe got cnt=%0d addr=%h expected 1/1", strobe_cnt - s0, word_addr);
    end
  endtask

  task automatic test_misc_regs;
    int s0;
    s0 = strobe_cnt;
    spi_frame(32'h0F01, 16);
    n_checks++;
    if (display_test !== 1'b1) begin n_fail++; $display("FAIL display_test got %b expected 1", display_test); end
    spi_frame(32'h0D55, 16);
    spi_frame(32'h0000, 16);
    spi_frame(32'h0807, 16);
    rd_addr = 3'd7; #1;
    n_checks++;
    if (rd_data !== 8'h07) begin n_fail++; $display("FAIL digit8 got %h expected 07", rd_data); end
    n_checks++;
    if (strobe_cnt - s0 !== 4) begin n_fail++; $display("FAIL ignored_strobes got %0d expected 4", strobe_cnt - s0); end
    n_checks++;
    if (intensity !== 4'h5 || decode_mode !== 8'h3F || scan_limit !== 3'h5 || shutdown_n !== 1'b1) begin
      n_fail++; $display("FAIL ignored_regs got i=%h dm=%h sl=%h sd=%b expected 5/3f/5/1",
                         intensity, decode_mode, scan_limit, shutdown_n);
    end
    n_checks++;
    if (pulse_err !== 0) begin n_fail++; $display("FAIL strobe_width got %0d long pulses expected 0", pulse_err); end
  endtask

  task automatic test_reset_midframe;
    logic [15:0] w;
    int s0;
    w = 16'h0C01;
    @(negedge clk);
    spi.cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 15; i >= 8; i--) begin
      spi.mosi = w[i];
      repeat (2) @(negedge clk);
      spi.sclk = 1'b1;
      repeat (2) @(negedge clk);
      spi.sclk = 1'b0;
    end
    res = 1'b0;
    spi.cs = 1'b1; spi.sclk = 1'b0; spi.mosi = 1'b0;
    repeat (3) @(negedge clk);
    res = 1'b1;
    repeat (6) @(negedge clk);
    s0 = strobe_cnt;
    n_checks++;
    if (shutdown_n !== 1'b0 || intensity !== 4'h0) begin
      n_fail++; $display("FAIL midreset_regs got sd=%b i=%h expected 0/0", shutdown_n, intensity);
    end
    spi_frame(32'h0201, 16);
    n_checks++;
    if (shutdown_n !== 1'b0) begin n_fail++; $display("FAIL midreset_shutdown_n got %b expected 0", shutdown_n); end
    rd_addr = 3'd1; #1;
    n_checks++;
    if (rd_data !== 8'h01) begin n_fail++; $display("FAIL midreset_digit2 got %h expected 01", rd_data); end
    n_checks++;
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL midreset_strobes got %0d expected 1", strobe_cnt - s0); end
  endtask

  initial begin
    spi.cs = 1'b1;
    spi.sclk = 1'b0;
    spi.mosi = 1'b0;
    test_reset();
    test_setup();
    test_digit_write();
    test_short_frame();
    test_long_frame();
    test_misc_regs();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
